// File: rtl/rv_decode_pkg.sv
// Shared constants and types for the RV32I decode/execute slice.
// Opcode, funct3/funct7 encodings, ALU and branch operation enums and the
// store-size encoding seen on store_type_o.
package rv_decode_pkg;

    // Major opcodes (inst[6:0])
    localparam logic [6:0] TYPE_U_LUI_OPCODE   = 7'b0110111;
    localparam logic [6:0] TYPE_U_AUIPC_OPCODE = 7'b0010111;
    localparam logic [6:0] TYPE_J_JAL_OPCODE   = 7'b1101111;
    localparam logic [6:0] TYPE_I_JALR_OPCODE  = 7'b1100111;
    localparam logic [6:0] TYPE_B_OPCODE       = 7'b1100011;
    localparam logic [6:0] TYPE_I_BASE_OPCODE  = 7'b0010011;
    localparam logic [6:0] TYPE_R_OPCODE       = 7'b0110011;
    localparam logic [6:0] TYPE_S_OPCODE       = 7'b0100011;
    localparam logic [6:0] TYPE_SYSTEM_OPCODE  = 7'b1110011;

    // The one SYSTEM encoding accepted by this slice
    localparam logic [31:0] TYPE_I_EBREAK = 32'h0010_0073;

    // funct3 encodings
    localparam logic [2:0] F3_JALR    = 3'b000;
    localparam logic [2:0] F3_ADDI    = 3'b000;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLT     = 3'b100;
    localparam logic [2:0] F3_BGE     = 3'b101;
    localparam logic [2:0] F3_BLTU    = 3'b110;
    localparam logic [2:0] F3_BGEU    = 3'b111;
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_SB      = 3'b000;
    localparam logic [2:0] F3_SH      = 3'b001;
    localparam logic [2:0] F3_SW      = 3'b010;

    // funct7 encodings: BASE for the plain op, ALT selects SUB / SRA
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Store size as presented on store_type_o
    localparam logic [1:0] STORE_NONE = 2'b00;
    localparam logic [1:0] STORE_BYTE = 2'b01;
    localparam logic [1:0] STORE_HALF = 2'b10;
    localparam logic [1:0] STORE_WORD = 2'b11;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_NONE,
        BR_EQ,
        BR_NE,
        BR_LT,
        BR_GE,
        BR_LTU,
        BR_GEU
    } br_type_e;

endpackage

// File: rtl/rv_regfile.sv
// 32 x DATA_LEN integer register file: two combinational read ports, one
// write port. x0 is hard-wired to zero. A synchronous active-low reset
// clears every entry. Reads in the write cycle return the old contents.
module rv_regfile #(
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          raddr1_i,
    input  logic [4:0]          raddr2_i,
    output logic [DATA_LEN-1:0] rdata1_o,
    output logic [DATA_LEN-1:0] rdata2_o,
    input  logic                wen_i,
    input  logic [4:0]          waddr_i,
    input  logic [DATA_LEN-1:0] wdata_i
);

    logic [DATA_LEN-1:0] regs_q [32];
    logic [DATA_LEN-1:0] regs_d [32];

    // Next register contents: clear on reset, else apply one write (never to x0)
    always_comb begin
        regs_d = regs_q;
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_d[i] = '0;
            end
        end else if (wen_i && (waddr_i != 5'd0)) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    // Register array update
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    assign rdata1_o = (raddr1_i == 5'd0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == 5'd0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/rv_decode_exec_rf.sv
// Single-cycle RV32I decode/execute slice with its register file.
// Decode, ALU and branch evaluation are combinational on inst_i/pc_i and the
// current register contents; write-back arrives on the reg_* write port.
// Build option: define RV_STORE_EN to accept SB/SH/SW; otherwise stores
// decode as invalid and the store outputs stay at zero.
module rv_decode_exec_rf
    import rv_decode_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         inst_i,
    input  logic [ADDR_LEN-1:0] pc_i,
    input  logic                reg_wen_i,
    input  logic [4:0]          reg_waddr_i,
    input  logic [DATA_LEN-1:0] reg_wdata_i,
    output logic                wd_o,
    output logic [4:0]          wreg_o,
    output logic [DATA_LEN-1:0] alu_result_o,
    output logic                branch_request_o,
    output logic [ADDR_LEN-1:0] branch_target_o,
    output logic                jmp_flag_o,
    output logic [ADDR_LEN-1:0] jmp_target_o,
    output logic                mem_wen_o,
    output logic [DATA_LEN-1:0] mem_wdata_o,
    output logic [1:0]          store_type_o,
    output logic                ebreak_o,
    output logic                invalid_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [DATA_LEN-1:0] rs1_val;
    logic [DATA_LEN-1:0] rs2_val;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];

    rv_regfile #(.DATA_LEN(DATA_LEN)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .raddr1_i (inst_i[19:15]),
        .raddr2_i (inst_i[24:20]),
        .rdata1_o (rs1_val),
        .rdata2_o (rs2_val),
        .wen_i    (reg_wen_i),
        .waddr_i  (reg_waddr_i),
        .wdata_i  (reg_wdata_i)
    );

    // Sign-extended immediates
    logic [DATA_LEN-1:0] imm_i;
    logic [DATA_LEN-1:0] imm_b;
    logic [DATA_LEN-1:0] imm_j;
    logic [DATA_LEN-1:0] imm_u;
    assign imm_i = {{(DATA_LEN-12){inst_i[31]}}, inst_i[31:20]};
    assign imm_b = {{(DATA_LEN-13){inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_j = {{(DATA_LEN-21){inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    assign imm_u = {{(DATA_LEN-32){inst_i[31]}}, inst_i[31:12], 12'b0};
`ifdef RV_STORE_EN
    logic [DATA_LEN-1:0] imm_s;
    assign imm_s = {{(DATA_LEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
`endif

    logic [DATA_LEN-1:0] jalr_sum;
    assign jalr_sum = rs1_val + imm_i;

    alu_op_e             alu_op;
    br_type_e            br_type;
    logic [DATA_LEN-1:0] op_a;
    logic [DATA_LEN-1:0] op_b;
    logic                wd;
    logic                jmp;
    logic [ADDR_LEN-1:0] jmp_target;
    logic                mem_wen;
    logic [DATA_LEN-1:0] mem_wdata;
    logic [1:0]          store_type;
    logic                ebreak;
    logic                invalid;

    // Decode: choose ALU operands/op and the control-flow / store side effects
    always_comb begin
        alu_op     = ALU_ADD;
        br_type    = BR_NONE;
        op_a       = '0;
        op_b       = '0;
        wd         = 1'b0;
        jmp        = 1'b0;
        jmp_target = '0;
        mem_wen    = 1'b0;
        mem_wdata  = '0;
        store_type = STORE_NONE;
        ebreak     = 1'b0;
        invalid    = 1'b0;
        case (opcode)
            TYPE_U_LUI_OPCODE: begin
                wd   = 1'b1;
                op_b = imm_u;
            end
            TYPE_U_AUIPC_OPCODE: begin
                wd   = 1'b1;
                op_a = DATA_LEN'(pc_i);
                op_b = imm_u;
            end
            TYPE_J_JAL_OPCODE: begin
                wd         = 1'b1;
                op_a       = DATA_LEN'(pc_i);
                op_b       = DATA_LEN'(4);
                jmp        = 1'b1;
                jmp_target = pc_i + ADDR_LEN'(imm_j);
            end
            TYPE_I_JALR_OPCODE: begin
                if (funct3 == F3_JALR) begin
                    wd         = 1'b1;
                    op_a       = DATA_LEN'(pc_i);
                    op_b       = DATA_LEN'(4);
                    jmp        = 1'b1;
                    jmp_target = ADDR_LEN'(jalr_sum) & ~ADDR_LEN'(1);
                end else begin
                    invalid = 1'b1;
                end
            end
            TYPE_B_OPCODE: begin
                case (funct3)
                    F3_BEQ:  br_type = BR_EQ;
                    F3_BNE:  br_type = BR_NE;
                    F3_BLT:  br_type = BR_LT;
                    F3_BGE:  br_type = BR_GE;
                    F3_BLTU: br_type = BR_LTU;
                    F3_BGEU: br_type = BR_GEU;
                    default: invalid = 1'b1;
                endcase
            end
            TYPE_I_BASE_OPCODE: begin
                if (funct3 == F3_ADDI) begin
                    wd   = 1'b1;
                    op_a = rs1_val;
                    op_b = imm_i;
                end else begin
                    invalid = 1'b1;
                end
            end
            TYPE_R_OPCODE: begin
                op_a = rs1_val;
                op_b = rs2_val;
                wd   = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD_SUB: alu_op = ALU_ADD;
                        F3_SLL:     alu_op = ALU_SLL;
                        F3_SLT:     alu_op = ALU_SLT;
                        F3_SLTU:    alu_op = ALU_SLTU;
                        F3_XOR:     alu_op = ALU_XOR;
                        F3_SRL_SRA: alu_op = ALU_SRL;
                        F3_OR:      alu_op = ALU_OR;
                        default:    alu_op = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
                    alu_op = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == F3_SRL_SRA) begin
                    alu_op = ALU_SRA;
                end else begin
                    wd      = 1'b0;
                    op_a    = '0;
                    op_b    = '0;
                    invalid = 1'b1;
                end
            end
            TYPE_S_OPCODE: begin
`ifdef RV_STORE_EN
                case (funct3)
                    F3_SB:   store_type = STORE_BYTE;
                    F3_SH:   store_type = STORE_HALF;
                    F3_SW:   store_type = STORE_WORD;
                    default: invalid    = 1'b1;
                endcase
                if (!invalid) begin
                    op_a      = rs1_val;
                    op_b      = imm_s;
                    mem_wen   = 1'b1;
                    mem_wdata = rs2_val;
                end
`else
                invalid = 1'b1;
`endif
            end
            TYPE_SYSTEM_OPCODE: begin
                if (inst_i == TYPE_I_EBREAK) begin
                    ebreak = 1'b1;
                end else begin
                    invalid = 1'b1;
                end
            end
            default: invalid = 1'b1;
        endcase
    end

    logic [DATA_LEN-1:0] alu_result;

    // ALU: all arithmetic wraps at DATA_LEN bits, shifts use op_b[4:0]
    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD:  alu_result = op_a + op_b;
            ALU_SUB:  alu_result = op_a - op_b;
            ALU_SLL:  alu_result = op_a << op_b[4:0];
            ALU_SLT:  alu_result = {{(DATA_LEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_result = {{(DATA_LEN-1){1'b0}}, (op_a < op_b)};
            ALU_XOR:  alu_result = op_a ^ op_b;
            ALU_SRL:  alu_result = op_a >> op_b[4:0];
            ALU_SRA:  alu_result = $unsigned($signed(op_a) >>> op_b[4:0]);
            ALU_OR:   alu_result = op_a | op_b;
            ALU_AND:  alu_result = op_a & op_b;
            default:  alu_result = '0;
        endcase
    end

    logic br_taken;

    // Branch condition on the two register operands
    always_comb begin
        br_taken = 1'b0;
        case (br_type)
            BR_EQ:   br_taken = (rs1_val == rs2_val);
            BR_NE:   br_taken = (rs1_val != rs2_val);
            BR_LT:   br_taken = ($signed(rs1_val) < $signed(rs2_val));
            BR_GE:   br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            BR_LTU:  br_taken = (rs1_val < rs2_val);
            BR_GEU:  br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    // Control outputs are held low while reset is asserted
    assign wd_o             = rst & wd;
    assign branch_request_o = rst & br_taken;
    assign jmp_flag_o       = rst & jmp;
    assign mem_wen_o        = rst & mem_wen;
    assign ebreak_o         = rst & ebreak;
    assign invalid_o        = rst & invalid;

    assign wreg_o          = inst_i[11:7];
    assign alu_result_o    = alu_result;
    assign branch_target_o = pc_i + ADDR_LEN'(imm_b);
    assign jmp_target_o    = jmp_target;
    assign mem_wdata_o     = mem_wdata;
    assign store_type_o    = store_type;

endmodule

// File: tb/tb_rv_decode_exec_rf.sv
// Self-checking bench for rv_decode_exec_rf: directed steps followed by
// randomized instructions compared against an instruction-level model that
// keeps its own copy of the architectural registers.
module tb_rv_decode_exec_rf;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_i;
    logic [31:0] pc_i;
    logic        reg_wen_i;
    logic [4:0]  reg_waddr_i;
    logic [31:0] reg_wdata_i;
    logic        wd_o;
    logic [4:0]  wreg_o;
    logic [31:0] alu_result_o;
    logic        branch_request_o;
    logic [31:0] branch_target_o;
    logic        jmp_flag_o;
    logic [31:0] jmp_target_o;
    logic        mem_wen_o;
    logic [31:0] mem_wdata_o;
    logic [1:0]  store_type_o;
    logic        ebreak_o;
    logic        invalid_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] ref_regs [32];

    rv_decode_exec_rf #(.DATA_LEN(32), .ADDR_LEN(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .inst_i           (inst_i),
        .pc_i             (pc_i),
        .reg_wen_i        (reg_wen_i),
        .reg_waddr_i      (reg_waddr_i),
        .reg_wdata_i      (reg_wdata_i),
        .wd_o             (wd_o),
        .wreg_o           (wreg_o),
        .alu_result_o     (alu_result_o),
        .branch_request_o (branch_request_o),
        .branch_target_o  (branch_target_o),
        .jmp_flag_o       (jmp_flag_o),
        .jmp_target_o     (jmp_target_o),
        .mem_wen_o        (mem_wen_o),
        .mem_wdata_o      (mem_wdata_o),
        .store_type_o     (store_type_o),
        .ebreak_o         (ebreak_o),
        .invalid_o        (invalid_o)
    );

    // Clock
    always #5 clk = ~clk;

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic        wd;
        logic [31:0] alu;
        logic        care_alu;
        logic        br;
        logic [31:0] brt;
        logic        jmp;
        logic [31:0] jt;
        logic        mwen;
        logic [31:0] mwd;
        logic [1:0]  st;
        logic        ebreak;
        logic        inval;
    } exp_t;

    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc);
        exp_t e;
        logic [31:0] a, b, imm_i, imm_s, imm_b, imm_j, imm_u;
        logic [2:0]  f3;
        logic [6:0]  f7;
        a     = ref_regs[inst[19:15]];
        b     = ref_regs[inst[24:20]];
        f3    = inst[14:12];
        f7    = inst[31:25];
        imm_i = 32'(signed'(inst[31:20]));
        imm_s = 32'(signed'({inst[31:25], inst[11:7]}));
        imm_b = 32'(signed'({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
        imm_j = 32'(signed'({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
        imm_u = {inst[31:12], 12'h000};
        e.wd = 0; e.alu = 0; e.care_alu = 0; e.br = 0; e.jmp = 0; e.jt = 0;
        e.mwen = 0; e.mwd = 0; e.st = 0; e.ebreak = 0; e.inval = 0;
        e.brt = pc + imm_b;
        case (inst[6:0])
            7'h37: begin e.wd = 1; e.care_alu = 1; e.alu = imm_u; end
            7'h17: begin e.wd = 1; e.care_alu = 1; e.alu = pc + imm_u; end
            7'h6F: begin
                e.wd = 1; e.care_alu = 1; e.alu = pc + 4;
                e.jmp = 1; e.jt = pc + imm_j;
            end
            7'h67: begin
                if (f3 == 0) begin
                    e.wd = 1; e.care_alu = 1; e.alu = pc + 4;
                    e.jmp = 1; e.jt = (a + imm_i) & 32'hFFFF_FFFE;
                end else e.inval = 1;
            end
            7'h63: begin
                case (f3)
                    3'd0: e.br = (a == b);
                    3'd1: e.br = (a != b);
                    3'd4: e.br = ($signed(a) < $signed(b));
                    3'd5: e.br = ($signed(a) >= $signed(b));
                    3'd6: e.br = (a < b);
                    3'd7: e.br = (a >= b);
                    default: e.inval = 1;
                endcase
            end
            7'h13: begin
                if (f3 == 0) begin e.wd = 1; e.care_alu = 1; e.alu = a + imm_i; end
                else e.inval = 1;
            end
            7'h33: begin
                e.wd = 1; e.care_alu = 1;
                case ({f7, f3})
                    {7'h00, 3'd0}: e.alu = a + b;
                    {7'h20, 3'd0}: e.alu = a - b;
                    {7'h00, 3'd1}: e.alu = a << b[4:0];
                    {7'h00, 3'd2}: e.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    {7'h00, 3'd3}: e.alu = (a < b) ? 32'd1 : 32'd0;
                    {7'h00, 3'd4}: e.alu = a ^ b;
                    {7'h00, 3'd5}: e.alu = a >> b[4:0];
                    {7'h20, 3'd5}: e.alu = 32'($signed(a) >>> b[4:0]);
                    {7'h00, 3'd6}: e.alu = a | b;
                    {7'h00, 3'd7}: e.alu = a & b;
                    default: begin e.inval = 1; e.wd = 0; e.care_alu = 0; end
                endcase
            end
            7'h23: begin
`ifdef RV_STORE_EN
                if (f3 <= 3'd2) begin
                    e.mwen = 1; e.mwd = b; e.st = 2'(f3) + 2'd1;
                    e.care_alu = 1; e.alu = a + imm_s;
                end else e.inval = 1;
`else
                e.inval = 1;
                if (imm_s == 32'hFFFF_FFFF) e.inval = 1;
`endif
            end
            7'h73: begin
                if (inst == 32'h0010_0073) e.ebreak = 1;
                else e.inval = 1;
            end
            default: e.inval = 1;
        endcase
        return e;
    endfunction

    // ---------------- checking / driver tasks ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        exp_t e;
        e = model(inst_i, pc_i);
        check({tag, ".wreg"}, 32'(wreg_o), 32'(inst_i[11:7]));
        check({tag, ".wd"}, 32'(wd_o), 32'(e.wd));
        check({tag, ".br"}, 32'(branch_request_o), 32'(e.br));
        check({tag, ".brt"}, branch_target_o, e.brt);
        check({tag, ".jmp"}, 32'(jmp_flag_o), 32'(e.jmp));
        check({tag, ".mwen"}, 32'(mem_wen_o), 32'(e.mwen));
        check({tag, ".mwd"}, mem_wdata_o, e.mwd);
        check({tag, ".st"}, 32'(store_type_o), 32'(e.st));
        check({tag, ".ebreak"}, 32'(ebreak_o), 32'(e.ebreak));
        check({tag, ".inval"}, 32'(invalid_o), 32'(e.inval));
        if (e.care_alu) check({tag, ".alu"}, alu_result_o, e.alu);
        if (e.jmp) check({tag, ".jt"}, jmp_target_o, e.jt);
    endtask

    task automatic apply(input logic [31:0] inst, input logic [31:0] pc);
        @(negedge clk);
        inst_i = inst;
        pc_i   = pc;
        #1;
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        reg_wen_i   = 1'b1;
        reg_waddr_i = addr;
        reg_wdata_i = data;
        @(posedge clk);
        if (rst && addr != 5'd0) ref_regs[addr] = data;
        @(negedge clk);
        reg_wen_i = 1'b0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        int          sel, k;
        rd  = 5'($urandom_range(0, 31));
        rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31));
        f3  = 3'($urandom_range(0, 7));
        k   = $urandom_range(0, 9);
        f7  = (k < 5) ? 7'h00 : (k < 9) ? 7'h20 : 7'($urandom);
        sel = $urandom_range(0, 11);
        case (sel)
            0:  return enc_u(20'($urandom), rd, 7'h37);
            1:  return enc_u(20'($urandom), rd, 7'h17);
            2:  return enc_j(21'($urandom), rd);
            3:  return enc_i(12'($urandom), rs1, (k < 8) ? 3'd0 : f3, rd, 7'h67);
            4:  return enc_b(13'($urandom), rs2, rs1, f3);
            5:  return enc_i(12'($urandom), rs1, (k < 6) ? 3'd0 : f3, rd, 7'h13);
            6,
            7:  return enc_r(f7, rs2, rs1, f3, rd);
            8:  return enc_s(12'($urandom), rs2, rs1, (k < 8) ? 3'($urandom_range(0, 2)) : f3);
            9:  return (k < 5) ? 32'h0010_0073 : enc_i(12'($urandom), rs1, f3, rd, 7'h73);
            default: return $urandom;
        endcase
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] v;
        int          k;
        rst         = 1'b0;
        inst_i      = 32'h0;
        pc_i        = 32'h0;
        reg_wen_i   = 1'b0;
        reg_waddr_i = 5'd0;
        reg_wdata_i = 32'h0;
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
        repeat (2) @(posedge clk);

        // Outputs forced low while in reset
        apply(enc_j(21'h20, 5'd1), 32'h8000_0010);
        check("rst_jmp", 32'(jmp_flag_o), 32'd0);
        check("rst_wd", 32'(wd_o), 32'd0);
        apply(32'hFFFF_FFFF, 32'h0);
        check("rst_invalid", 32'(invalid_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Reset then read
        apply(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'h0);
        check("add_after_rst", alu_result_o, 32'h0);
        check("add_wd", 32'(wd_o), 32'd1);
        check("add_wreg", 32'(wreg_o), 32'd3);

        // ADDI / SLT / SLTU
        apply(enc_i(12'hFFB, 5'd0, 3'd0, 5'd1, 7'h13), 32'h0);
        check("addi_neg5", alu_result_o, 32'hFFFF_FFFB);
        write_reg(5'd1, 32'hFFFF_FFFB);
        apply(enc_r(7'h00, 5'd0, 5'd1, 3'd2, 5'd2), 32'h0);
        check("slt", alu_result_o, 32'd1);
        apply(enc_r(7'h00, 5'd0, 5'd1, 3'd3, 5'd2), 32'h0);
        check("sltu", alu_result_o, 32'd0);

        // x0 is immutable
        write_reg(5'd0, 32'h1234);
        apply(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd5), 32'h0);
        check("x0_zero", alu_result_o, 32'h0);

        // No write-through: same-cycle read sees the old value
        write_reg(5'd13, 32'h1111);
        @(negedge clk);
        inst_i      = enc_r(7'h00, 5'd0, 5'd13, 3'd0, 5'd12);
        reg_wen_i   = 1'b1;
        reg_waddr_i = 5'd13;
        reg_wdata_i = 32'h5555;
        #1;
        check("no_bypass_old", alu_result_o, 32'h1111);
        @(posedge clk);
        ref_regs[13] = 32'h5555;
        #1;
        check("no_bypass_new", alu_result_o, 32'h5555);
        @(negedge clk);
        reg_wen_i = 1'b0;

        // Write during reset is dropped and reset clears the file
        @(negedge clk);
        rst         = 1'b0;
        reg_wen_i   = 1'b1;
        reg_waddr_i = 5'd7;
        reg_wdata_i = 32'd55;
        @(posedge clk);
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
        @(negedge clk);
        reg_wen_i = 1'b0;
        rst       = 1'b1;
        apply(enc_r(7'h00, 5'd0, 5'd7, 3'd0, 5'd5), 32'h0);
        check("wr_in_rst", alu_result_o, 32'h0);
        apply(enc_r(7'h00, 5'd0, 5'd13, 3'd0, 5'd5), 32'h0);
        check("rst_clears", alu_result_o, 32'h0);

        // JAL / JALR
        apply(enc_j(21'h20, 5'd1), 32'h8000_0010);
        check("jal_flag", 32'(jmp_flag_o), 32'd1);
        check("jal_target", jmp_target_o, 32'h8000_0030);
        check("jal_link", alu_result_o, 32'h8000_0014);
        write_reg(5'd6, 32'h8000_0101);
        apply(enc_i(12'h000, 5'd6, 3'd0, 5'd1, 7'h67), 32'h8000_0010);
        check("jalr_target", jmp_target_o, 32'h8000_0100);
        check("jalr_br", 32'(branch_request_o), 32'd0);

        // BNE
        write_reg(5'd1, 32'd1);
        write_reg(5'd2, 32'd2);
        apply(enc_b(13'h1FF8, 5'd2, 5'd1, 3'd1), 32'h8000_0000);
        check("bne_taken", 32'(branch_request_o), 32'd1);
        check("bne_target", branch_target_o, 32'h7FFF_FFF8);
        check("bne_wd", 32'(wd_o), 32'd0);
        apply(enc_b(13'h1FF8, 5'd1, 5'd1, 3'd1), 32'h8000_0000);
        check("bne_equal", 32'(branch_request_o), 32'd0);

        // EBREAK / invalid
        apply(32'h0010_0073, 32'h0);
        check("ebreak", 32'(ebreak_o), 32'd1);
        check("ebreak_inval", 32'(invalid_o), 32'd0);
        apply(32'hFFFF_FFFF, 32'h0);
        check("ones_inval", 32'(invalid_o), 32'd1);
        check("ones_wd", 32'(wd_o), 32'd0);

        // Store
        write_reg(5'd10, 32'h100);
        write_reg(5'd11, 32'hDEAD);
        apply(enc_s(12'd4, 5'd11, 5'd10, 3'd2), 32'h0);
`ifdef RV_STORE_EN
        check("sw_wen", 32'(mem_wen_o), 32'd1);
        check("sw_addr", alu_result_o, 32'h104);
        check("sw_data", mem_wdata_o, 32'hDEAD);
        check("sw_type", 32'(store_type_o), 32'd3);
        check("sw_wd", 32'(wd_o), 32'd0);
`else
        check("sw_inval", 32'(invalid_o), 32'd1);
        check("sw_wen", 32'(mem_wen_o), 32'd0);
        check("sw_type", 32'(store_type_o), 32'd0);
        check("sw_data", mem_wdata_o, 32'd0);
`endif

        // Randomized: populate registers, then mixed instructions
        for (int i = 1; i < 32; i++) begin
            k = $urandom_range(0, 3);
            v = (k == 0) ? 32'($urandom_range(0, 40)) : (k == 1) ? 32'h8000_0000 ^ 32'($urandom_range(0, 3)) : $urandom;
            write_reg(5'(i), v);
        end
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, 2);
                v = (k == 0) ? 32'($urandom_range(0, 40)) : $urandom;
                write_reg(5'($urandom_range(0, 31)), v);
            end
            apply(rand_inst(), $urandom & 32'hFFFF_FFFC);
            check_all("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_decode_exec_rf.md
Name: rv_decode_exec_rf

Overview:
Single-cycle RV32I decode/execute slice: 32x32 integer register file, instruction decoder and ALU/branch unit. Takes the fetched instruction and its PC from the fetch stage. Produces the write-back request (rd, data), control-flow redirect (branch/jump target and flag) and store request. Write-back data returns through the register write port, driven by an external wb stage.

Parameters:
DATA_LEN, 32, datapath and register width
ADDR_LEN, 32, PC/address width

Ports:
clk  in  1  clock; register file writes on rising edge
rst  in  1  reset, synchronous, active-low
inst_i  in  32  instruction to decode
pc_i  in  ADDR_LEN  PC of inst_i
reg_wen_i  in  1  register write enable (from wb)
reg_waddr_i  in  5  register write address
reg_wdata_i  in  DATA_LEN  register write data
wd_o  out  1  instruction writes rd
wreg_o  out  5  rd index
alu_result_o  out  DATA_LEN  rd value, or store address
branch_request_o  out  1  conditional branch taken
branch_target_o  out  ADDR_LEN  pc_i + B-immediate
jmp_flag_o  out  1  unconditional jump (jal/jalr)
jmp_target_o  out  ADDR_LEN  jump target
mem_wen_o  out  1  store request
mem_wdata_o  out  DATA_LEN  store data (rs2)
store_type_o  out  2  00 none, 01 byte, 10 half, 11 word
ebreak_o  out  1  inst_i == 32'h00100073
invalid_o  out  1  inst_i not in supported set

Behaviour:
- Register file: 32 entries.
  - Two combinational read ports, addressed by inst_i[19:15] and inst_i[24:20].
  - x0 always reads 0; writes to x0 ignored.
  - Write at posedge clk when reg_wen_i=1 and rst=1.
  - No write-through bypass: a same-cycle read returns the old value.
- Reset: posedge clk with rst=0 clears all 32 registers.
  - While rst=0, these outputs are forced to 0: wd_o, branch_request_o, jmp_flag_o, mem_wen_o, ebreak_o, invalid_o.
- Decode/execute is purely combinational; latency 0. Results depend only on inst_i, pc_i and current register contents.
- Immediates are sign-extended: I, S, B (bit0=0), J (bit0=0); U = inst[31:12]<<12.
- Supported instructions:
  - LUI (0110111): rd = immU.
  - AUIPC (0010111): rd = pc_i + immU.
  - JAL (1101111): rd = pc_i+4; jmp_flag_o=1; jmp_target_o = pc_i + immJ.
  - JALR (1100111, f3=000): rd = pc_i+4; jmp_target_o = (rs1 + immI) & ~1.
  - BRANCH (1100011), f3 BEQ/BNE/BLT/BGE/BLTU/BGEU: signed/unsigned compare of rs1, rs2.
    - branch_request_o=1 when the condition holds; wd_o=0.
    - branch_target_o = pc_i + immB, always driven.
  - ADDI (0010011, f3=000): rd = rs1 + immI. Other OP-IMM funct3 are invalid.
  - OP (0110011): ADD, SUB (f7=0100000), SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
    - Shift amount = rs2[4:0].
    - Arithmetic wraps modulo 2^32.
  - EBREAK: ebreak_o=1, no side effects.
- Invalid instruction: invalid_o=1; wd_o, mem_wen_o, branch_request_o, jmp_flag_o all 0.
- wreg_o = inst_i[11:7] always. wd_o is asserted even when rd=0; the register file drops the write.
- jmp_flag_o and branch_request_o are never both 1.

Optional Feature:
RV_STORE_EN.
- Defined: STORE (0100011), f3 000/001/010 (SB/SH/SW) is valid.
  - alu_result_o = rs1 + immS; mem_wen_o=1; mem_wdata_o = rs2.
  - store_type_o = 01/10/11 for SB/SH/SW; wd_o=0.
- Undefined: stores are invalid; mem_wen_o=0, store_type_o=00, mem_wdata_o=0.

Decomposition:
- Package rv_decode_pkg holds:
  - opcode constants (TYPE_U_LUI_OPCODE, TYPE_U_AUIPC_OPCODE, TYPE_J_JAL_OPCODE, TYPE_I_JALR_OPCODE, TYPE_B_OPCODE, TYPE_I_BASE_OPCODE, TYPE_R_OPCODE, TYPE_S_OPCODE);
  - funct3/funct7 constants and TYPE_I_EBREAK;
  - ALU-op enum, branch-type enum, store-type encoding.
- One sub-module: rv_regfile (32x32, 2R1W, sync clear).
- Decoder and ALU stay in the top.

Test Plan:
- Reset then read: rst=0 for one edge, then inst_i=ADD x3,x1,x2 -> alu_result_o=0, wd_o=1, wreg_o=3.
- ADDI x1,x0,-5 -> alu_result_o=32'hFFFFFFFB. Write it back via reg_wen_i, then SLT x2,x1,x0 -> 1; SLTU -> 0.
- Write x0=32'h1234 via the write port -> ADD x5,x0,x0 gives 0. Write attempted during rst=0 -> ignored.
- pc_i=0x80000010, JAL x1,+0x20 -> jmp_flag_o=1, jmp_target_o=0x80000030, alu_result_o=0x80000014. JALR with rs1=0x80000101, imm=0 -> target 0x80000100.
- BNE, rs1=1, rs2=2, pc_i=0x80000000, imm=-8 -> branch_request_o=1, branch_target_o=0x7FFFFFF8. Equal operands -> 0.
- inst_i=32'h00100073 -> ebreak_o=1, invalid_o=0. inst_i=32'hFFFFFFFF -> invalid_o=1, wd_o=0. With RV_STORE_EN: SW rs2=0xDEAD at rs1=0x100, imm=4 -> mem_wen_o=1, addr 0x104, store_type_o=11.
